// File: rtl/decode_issue_queue.sv
// Decode-to-execute issue queue: DEPTH-entry FIFO of decoded bundles with flush and writeback snoop.
// Optional 0-cycle bypass into an empty queue is enabled by defining DECODE_IQ_BYPASS_EN.
module decode_issue_queue #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 18,
  parameter int DEPTH      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [CTRL_W-1:0]       i_ctrl,
  input  logic [ADDR_WIDTH-1:0]   i_pc,
  input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
  input  logic [DATA_WIDTH-1:0]   i_imm_ext,
  input  logic [DATA_WIDTH-1:0]   i_rs1_data,
  input  logic [DATA_WIDTH-1:0]   i_rs2_data,
  input  logic [REG_ADDR_W-1:0]   i_rs1_addr,
  input  logic [REG_ADDR_W-1:0]   i_rs2_addr,
  input  logic [REG_ADDR_W-1:0]   i_rd_addr,
  input  logic                    i_wb_we,
  input  logic [REG_ADDR_W-1:0]   i_wb_addr,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  input  logic                    i_flush,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [CTRL_W-1:0]       o_ctrl,
  output logic [ADDR_WIDTH-1:0]   o_pc,
  output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
  output logic [DATA_WIDTH-1:0]   o_imm_ext,
  output logic [DATA_WIDTH-1:0]   o_rs1_data,
  output logic [DATA_WIDTH-1:0]   o_rs2_data,
  output logic [REG_ADDR_W-1:0]   o_rs1_addr,
  output logic [REG_ADDR_W-1:0]   o_rs2_addr,
  output logic [REG_ADDR_W-1:0]   o_rd_addr,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [CTRL_W-1:0]     ctrl;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [REG_ADDR_W-1:0] rd_addr;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_entry;
  entry_t        out_entry;
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          wb_hit, not_empty, bypass, push, pop;

  assign wb_hit    = i_wb_we && (i_wb_addr != '0);
  assign not_empty = (count_q != '0);
  assign o_ready   = !i_arst && (count_q < CW'(DEPTH));

  // Incoming bundle with same-cycle writeback already folded into its operands.
  always_comb begin
    in_entry = '{ctrl: i_ctrl, pc: i_pc, pc_plus4: i_pc_plus4, imm_ext: i_imm_ext,
                 rs1_data: i_rs1_data, rs2_data: i_rs2_data, rs1_addr: i_rs1_addr,
                 rs2_addr: i_rs2_addr, rd_addr: i_rd_addr};
    if (wb_hit && (i_rs1_addr == i_wb_addr)) in_entry.rs1_data = i_wb_data;
    if (wb_hit && (i_rs2_addr == i_wb_addr)) in_entry.rs2_data = i_wb_data;
  end

`ifdef DECODE_IQ_BYPASS_EN
  assign bypass = !i_arst && !not_empty && i_valid;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed bundle that execute takes immediately never enters storage.
  assign push = i_valid && o_ready && !i_flush && !(bypass && i_ready);
  assign pop  = not_empty && i_ready;

  always_comb begin
    // NOTE: defaults first so every path assigns both signals and no latch is inferred.
    out_entry = '0;
    o_valid   = 1'b0;
    if (bypass) begin
      out_entry = in_entry;
      o_valid   = 1'b1;
    end else if (not_empty) begin
      out_entry = mem[head_q];
      o_valid   = 1'b1;
    end
  end

  assign o_ctrl     = out_entry.ctrl;
  assign o_pc       = out_entry.pc;
  assign o_pc_plus4 = out_entry.pc_plus4;
  assign o_imm_ext  = out_entry.imm_ext;
  assign o_rs1_data = out_entry.rs1_data;
  assign o_rs2_data = out_entry.rs2_data;
  assign o_rs1_addr = out_entry.rs1_addr;
  assign o_rs2_addr = out_entry.rs2_addr;
  assign o_rd_addr  = out_entry.rd_addr;
  assign o_count    = count_q;

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_arst || i_flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: entry storage is not reset; occupancy gates every read and empty outputs are forced to 0.
  // Snooping every slot is equivalent to snooping only live ones: dead slots are rewritten on push.
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wb_hit && (mem[i].rs1_addr == i_wb_addr)) mem[i].rs1_data <= i_wb_data;
      if (wb_hit && (mem[i].rs2_addr == i_wb_addr)) mem[i].rs2_data <= i_wb_data;
    end
    if (push) mem[tail_q] <= in_entry;
  end

endmodule

// File: doc/decode_issue_queue.md
# decode_issue_queue

Parametrised elastic buffer between the decode pipeline register and the execute stage. It replaces the fixed one-deep decode→execute register with a DEPTH-entry FIFO of decoded instruction bundles, using a valid/ready handshake on both sides. It supports whole-queue flush on branch/jump redirect. While an entry waits, it snoops the writeback port and updates its rs1/rs2 operand data, so queued operands never go stale.

## Interface
- ADDR_WIDTH, 64, PC width
- DATA_WIDTH, 64, register data and immediate width
- REG_ADDR_W, 5, register address width
- CTRL_W, 18, width of packed control bundle (result_src, alu_control, mem_we, reg_we, alu_src, branch, jump, pc_target_src, forward_src, load_instr, func3)
- DEPTH, 4, entry count; power of two, ≥2
- i_clk  in  1  clock, all state on rising edge
- i_arst  in  1  reset, synchronous, active-high
- i_valid  in  1  decode offers a bundle
- o_ready  out  1  queue accepts a bundle this cycle
- i_ctrl  in  CTRL_W  packed control bundle
- i_pc, i_pc_plus4  in  ADDR_WIDTH  PC and PC+4
- i_imm_ext  in  DATA_WIDTH  extended immediate
- i_rs1_data, i_rs2_data  in  DATA_WIDTH  register file read data
- i_rs1_addr, i_rs2_addr, i_rd_addr  in  REG_ADDR_W  register addresses
- i_wb_we  in  1  writeback write enable (same signal as register file write enable)
- i_wb_addr  in  REG_ADDR_W  writeback destination
- i_wb_data  in  DATA_WIDTH  writeback data
- i_flush  in  1  discard all entries (redirect)
- o_valid  out  1  head bundle available to execute
- i_ready  in  1  execute consumes head
- o_ctrl, o_pc, o_pc_plus4, o_imm_ext, o_rs1_data, o_rs2_data, o_rs1_addr, o_rs2_addr, o_rd_addr  out  as inputs  head bundle
- o_count  out  $clog2(DEPTH)+1  current occupancy

## Operation
- Push: i_valid && o_ready. The bundle is written at the tail; the tail pointer increments modulo DEPTH.
- Pop: o_valid && i_ready. The head pointer increments modulo DEPTH.
- o_ready = (count < DEPTH). It does not depend on i_ready, so there is no combinational ready path. A full queue rejects a push even if a pop happens in the same cycle.
- Simultaneous push and pop (not full, not empty): count is unchanged and both pointers advance.
- Writeback snoop: the condition is i_wb_we && i_wb_addr != 0. At each edge:
  - every valid entry whose rs1_addr == i_wb_addr has rs1_data replaced by i_wb_data; rs2 is handled the same way;
  - the bundle being pushed in the same cycle is also patched before storage.
- An entry popped in the same cycle as a matching writeback leaves with the unpatched value. The execute forwarding unit covers this case.
- Register x0 is never patched.
- Flush:
  - count, head and tail go to 0 at the next edge;
  - a push in the flush cycle is discarded;
  - a pop in the flush cycle still completes (execute ignores it; the hazard unit owns that).
- Flush has priority over push and pop.
- When o_valid=0, all data outputs are driven 0 and o_ctrl=0 (a bubble, with reg_we and mem_we deasserted).

## Timing
- Reset (i_arst high at an edge):
  - o_valid=0, o_count=0, all outputs 0, pointers 0;
  - o_ready=0 while i_arst is high, and 1 from the first cycle after reset deasserts.
- Latency without bypass: a push at edge N appears on o_valid/outputs after edge N, i.e. 1 cycle. This matches the old single register.
- Throughput: one push and one pop per cycle.
- Full: o_ready=0 until a pop edge; it becomes 1 the cycle after the pop.
- Reset mid-operation: all entries are lost, with the same result as flush, plus o_ready=0 during reset.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. Count never exceeds DEPTH or underflows.

## Configuration
- DECODE_IQ_BYPASS_EN defined: when count==0 and i_valid=1, the input bundle is driven combinationally to the outputs with o_valid=1, including same-cycle writeback patching.
  - If i_ready=1 as well, the bundle is not stored and count stays 0, giving 0-cycle latency.
  - If i_ready=0, the bundle is stored normally.
- DECODE_IQ_BYPASS_EN undefined: there is no input-to-output path and latency is always ≥1 cycle.

## Test plan
- Reset: hold i_arst 2 cycles → o_valid=0, o_count=0, o_ready=0, then o_ready=1 after release.
- Fill/drain, DEPTH=4, i_ready=0: push pc=0x100,0x104,0x108,0x10C → o_count=4, o_ready=0, and a 5th push is ignored. Then hold i_ready=1 → pcs leave in order 0x100..0x10C, followed by o_valid=0 and all outputs 0.
- Wrap and streaming: 10 back-to-back pushes with i_ready=1 → o_count stays at 1 and the output pc sequence is identical to the input sequence.
- Snoop:
  - queue an entry with rs1_addr=5, rs1_data=0x11, hold i_ready=0, and write back x5=0xDEAD → next cycle o_rs1_data=0xDEAD;
  - the same test with i_wb_addr=0 → the value stays 0x11.
- Flush: queue 3 entries, assert i_flush together with i_valid → next cycle o_count=0, o_valid=0, and the flush-cycle bundle is absent.
- Bypass: with DECODE_IQ_BYPASS_EN defined, push into an empty queue with i_ready=1 → o_valid=1 in the same cycle, o_pc equals i_pc, and o_count stays 0. Without the macro, o_valid rises one cycle later.
